// File: rtl/l1d_wb_beat_issuer.sv
// L1D writeback beat issuer: takes one line from the writeback FIFO and issues it as an AW phase, W beats, then waits for B.
// Optional error replay (up to 3 retries) is enabled by defining L1D_WB_ERR_RETRY_EN.
module l1d_wb_beat_issuer #(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned LINE_WIDTH = 512,
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned BUS_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LINE_WIDTH-1:0] req_data_i,
  output logic                  req_rdy_o,
  input  logic                  flush_i,
  output logic                  aw_vld_o,
  input  logic                  aw_rdy_i,
  output logic [ADDR_WIDTH-1:0] aw_addr_o,
  output logic [ID_WIDTH-1:0]   aw_id_o,
  output logic [7:0]            aw_len_o,
  output logic                  w_vld_o,
  input  logic                  w_rdy_i,
  output logic [BEAT_WIDTH-1:0] w_data_o,
  output logic                  w_last_o,
  input  logic                  b_vld_i,
  output logic                  b_rdy_o,
  input  logic [1:0]            b_resp_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W      = $clog2(BEATS);
  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;

  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    accept;
  logic                    err_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BEAT_WIDTH-1:0]   beats_q [BEATS];

`ifdef L1D_WB_ERR_RETRY_EN
  logic [1:0]              retry_q, retry_d;
`endif

  assign req_rdy_o = (state_q == ST_IDLE) && !flush_i;

  // Address/ID/length are constant or held in the capture register for the whole transaction.
  assign aw_addr_o = addr_q;
  assign aw_id_o   = ID_WIDTH'(BUS_ID);
  assign aw_len_o  = 8'(BEATS - 1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`ifdef L1D_WB_ERR_RETRY_EN
      retry_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef L1D_WB_ERR_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    err_d   = 1'b0;
`ifdef L1D_WB_ERR_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_vld_i && req_rdy_o) begin
          accept  = 1'b1;
          state_d = ST_AW;
`ifdef L1D_WB_ERR_RETRY_EN
          retry_d = 2'd0;
`endif
        end
      end
      ST_AW: begin
        if (aw_rdy_i) begin
          state_d = ST_W;
          cnt_d   = '0;
        end
      end
      ST_W: begin
        if (w_rdy_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        if (b_vld_i) begin
          if (b_resp_i == 2'b00) begin
            state_d = ST_IDLE;
          end else begin
`ifdef L1D_WB_ERR_RETRY_EN
            // Replay the held line from beat 0 until three retries are spent.
            if (retry_q != 2'd3) begin
              retry_d = retry_q + 2'd1;
              state_d = ST_AW;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
`else
            err_d   = 1'b1;
            state_d = ST_IDLE;
`endif
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_vld_o <= 1'b0;
      w_vld_o  <= 1'b0;
      w_last_o <= 1'b0;
      w_data_o <= '0;
      b_rdy_o  <= 1'b0;
      busy_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      aw_vld_o <= (state_d == ST_AW);
      w_vld_o  <= (state_d == ST_W);
      w_last_o <= (state_d == ST_W) && (cnt_d == LAST_BEAT);
      b_rdy_o  <= (state_d == ST_B);
      busy_o   <= (state_d != ST_IDLE);
      err_o    <= err_d;
      if (state_d == ST_W) begin
        w_data_o <= beats_q[cnt_d];
      end
    end
  end

  // Line capture; contents are only meaningful while a request is held.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= req_addr_i & ADDR_MASK;
      for (int unsigned i = 0; i < BEATS; i++) begin
        beats_q[i] <= req_data_i[i*BEAT_WIDTH +: BEAT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_l1d_wb_beat_issuer.sv
// Randomized bench for l1d_wb_beat_issuer against a transaction-level model of the write bus.
// Builds with or without L1D_WB_ERR_RETRY_EN.
module tb_l1d_wb_beat_issuer;

  localparam int unsigned ADDR_WIDTH = 40;
  localparam int unsigned LINE_WIDTH = 512;
  localparam int unsigned BEAT_WIDTH = 64;
  localparam int unsigned ID_WIDTH   = 4;
  localparam int unsigned BUS_ID     = 0;
  localparam int unsigned BEATS      = LINE_WIDTH / BEAT_WIDTH;
`ifdef L1D_WB_ERR_RETRY_EN
  localparam int unsigned MAX_RETRY  = 3;
`else
  localparam int unsigned MAX_RETRY  = 0;
`endif

  logic                  clk;
  logic                  rst;
  logic                  req_vld_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [LINE_WIDTH-1:0] req_data_i;
  logic                  req_rdy_o;
  logic                  flush_i;
  logic                  aw_vld_o;
  logic                  aw_rdy_i;
  logic [ADDR_WIDTH-1:0] aw_addr_o;
  logic [ID_WIDTH-1:0]   aw_id_o;
  logic [7:0]            aw_len_o;
  logic                  w_vld_o;
  logic                  w_rdy_i;
  logic [BEAT_WIDTH-1:0] w_data_o;
  logic                  w_last_o;
  logic                  b_vld_i;
  logic                  b_rdy_o;
  logic [1:0]            b_resp_i;
  logic                  busy_o;
  logic                  err_o;

  l1d_wb_beat_issuer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LINE_WIDTH(LINE_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH),
    .ID_WIDTH  (ID_WIDTH),
    .BUS_ID    (BUS_ID)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld_i (req_vld_i),
    .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .req_rdy_o (req_rdy_o),
    .flush_i   (flush_i),
    .aw_vld_o  (aw_vld_o),
    .aw_rdy_i  (aw_rdy_i),
    .aw_addr_o (aw_addr_o),
    .aw_id_o   (aw_id_o),
    .aw_len_o  (aw_len_o),
    .w_vld_o   (w_vld_o),
    .w_rdy_i   (w_rdy_i),
    .w_data_o  (w_data_o),
    .w_last_o  (w_last_o),
    .b_vld_i   (b_vld_i),
    .b_rdy_o   (b_rdy_o),
    .b_resp_i  (b_resp_i),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model: what the bus still owes for the held line.
  bit                    m_pend;
  bit                    m_aw_owed;
  bit                    m_err;
  int unsigned           m_tries;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [BEAT_WIDTH-1:0] m_line [BEATS];
  logic [BEAT_WIDTH-1:0] m_beats [$];

  // Stimulus knobs (percent probabilities).
  int unsigned p_req, p_flush, p_aw, p_w, p_b, p_err;
  bit          fix_stim;
  bit          nostall_chk;
  int unsigned busy_run;
  int unsigned n_accept;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pct(input int unsigned p);
    return $urandom_range(99) < p;
  endfunction

  task automatic refill();
    m_beats.delete();
    for (int k = 0; k < BEATS; k++) m_beats.push_back(m_line[k]);
  endtask

  // One clock: check registered outputs, drive inputs, check req_rdy_o, advance the model.
  task automatic step(input bit do_rst);
    bit acc;
    @(negedge clk);
    check("busy", 64'(busy_o), 64'(m_pend));
    check("aw_vld", 64'(aw_vld_o), 64'(m_pend && m_aw_owed));
    check("w_vld", 64'(w_vld_o), 64'(m_pend && !m_aw_owed && m_beats.size() != 0));
    check("b_rdy", 64'(b_rdy_o), 64'(m_pend && !m_aw_owed && m_beats.size() == 0));
    check("err", 64'(err_o), 64'(m_err));
    if (aw_vld_o) begin
      check("aw_addr", 64'(aw_addr_o), 64'(m_addr));
      check("aw_len", 64'(aw_len_o), 64'(BEATS - 1));
      check("aw_id", 64'(aw_id_o), 64'(BUS_ID));
      if (fix_stim) check("aw_addr_fixed", 64'(aw_addr_o), 64'h1_2345_6780);
    end
    if (w_vld_o && m_beats.size() != 0) begin
      check("w_data", 64'(w_data_o), 64'(m_beats[0]));
      check("w_last", 64'(w_last_o), 64'(m_beats.size() == 1));
    end
    if (busy_o) busy_run++;
    else begin
      if (nostall_chk && busy_run != 0) check("busy_len", 64'(busy_run), 64'(BEATS + 2));
      busy_run = 0;
    end

    rst       = do_rst;
    req_vld_i = pct(p_req);
    req_addr_i = fix_stim ? ADDR_WIDTH'(40'h1_2345_6789) : ADDR_WIDTH'({$urandom(), $urandom()});
    for (int k = 0; k < BEATS; k++)
      req_data_i[k*BEAT_WIDTH +: BEAT_WIDTH] = fix_stim ? 64'(k) : {$urandom(), $urandom()};
    flush_i  = pct(p_flush);
    aw_rdy_i = pct(p_aw);
    w_rdy_i  = pct(p_w);
    b_vld_i  = pct(p_b);
    b_resp_i = pct(p_err) ? 2'(1 + $urandom_range(2)) : 2'b00;
    #1;
    check("req_rdy", 64'(req_rdy_o), 64'(!m_pend && !flush_i));

    acc   = req_vld_i && !m_pend && !flush_i;
    m_err = 1'b0;
    if (do_rst) begin
      m_pend    = 1'b0;
      m_aw_owed = 1'b0;
      m_beats.delete();
    end else if (acc) begin
      n_accept++;
      m_pend    = 1'b1;
      m_aw_owed = 1'b1;
      m_tries   = 0;
      m_addr    = req_addr_i & ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
      for (int k = 0; k < BEATS; k++) m_line[k] = req_data_i[k*BEAT_WIDTH +: BEAT_WIDTH];
      refill();
    end else if (m_pend) begin
      if (m_aw_owed) begin
        if (aw_rdy_i) m_aw_owed = 1'b0;
      end else if (m_beats.size() != 0) begin
        if (w_rdy_i) void'(m_beats.pop_front());
      end else if (b_vld_i) begin
        if (b_resp_i == 2'b00) m_pend = 1'b0;
        else if (m_tries < MAX_RETRY) begin
          m_tries++;
          m_aw_owed = 1'b1;
          refill();
        end else begin
          m_pend = 1'b0;
          m_err  = 1'b1;
        end
      end
    end
  endtask

  task automatic set_knobs(input int unsigned req, input int unsigned fl, input int unsigned aw,
                           input int unsigned w, input int unsigned b, input int unsigned er);
    p_req = req; p_flush = fl; p_aw = aw; p_w = w; p_b = b; p_err = er;
  endtask

  initial begin
    bit reached;
    rst = 1'b1; req_vld_i = 1'b0; req_addr_i = '0; req_data_i = '0; flush_i = 1'b0;
    aw_rdy_i = 1'b0; w_rdy_i = 1'b0; b_vld_i = 1'b0; b_resp_i = 2'b00;
    m_pend = 1'b0; m_aw_owed = 1'b0; m_err = 1'b0; m_tries = 0; m_addr = '0;
    fix_stim = 1'b0; nostall_chk = 1'b0; busy_run = 0; n_accept = 0;
    set_knobs(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    repeat (3) step(1'b1);

    // Nominal zero-stall bursts with fixed address/data, req_vld_i held high.
    fix_stim = 1'b1; nostall_chk = 1'b1;
    set_knobs(100, 0, 100, 100, 100, 0);
    repeat (40) step(1'b0);
    fix_stim = 1'b0; nostall_chk = 1'b0;

    // W back-pressure.
    set_knobs(100, 0, 100, 50, 100, 0);
    repeat (200) step(1'b0);

    // Heavy flush, random readies.
    set_knobs(80, 60, 60, 60, 60, 0);
    repeat (300) step(1'b0);

    // Mixed error responses, then persistent error.
    set_knobs(70, 10, 70, 70, 70, 50);
    repeat (400) step(1'b0);
    set_knobs(100, 0, 100, 100, 100, 100);
    repeat (150) step(1'b0);

    // Reset while beat 3 is on the bus.
    set_knobs(100, 0, 100, 100, 100, 0);
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      step(1'b0);
      reached = m_pend && !m_aw_owed && (m_beats.size() == BEATS - 3);
    end
    check("beat3_reached", 64'(reached), 64'd1);
    step(1'b1);
    repeat (30) step(1'b0);

    // Long random soak with occasional resets.
    set_knobs(60, 20, 60, 60, 60, 30);
    for (int i = 0; i < 1500; i++) step(pct(1));

    check("accept_count", 64'(n_accept > 20), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l1d_wb_beat_issuer.md
Name: l1d_wb_beat_issuer

Overview:
- Sits directly downstream of the L1D writeback-request FIFO.
- Takes one line-sized writeback request (address + full line data) through a valid/ready handshake.
- Issues the request on the memory-side write bus as one address phase, then LINE_WIDTH/BEAT_WIDTH data beats, then waits for the write response.
- Holds one request at a time. The FIFO absorbs back-pressure while this block is busy.

Parameters:
- ADDR_WIDTH, 40: physical address width of a request.
- LINE_WIDTH, 512: cache line width in bits.
- BEAT_WIDTH, 64: bus data beat width in bits. LINE_WIDTH must be an integer multiple of BEAT_WIDTH, with at least 2 beats.
- ID_WIDTH, 4: bus transaction ID width.
- BUS_ID, 0: constant ID driven on aw_id_o.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_vld_i  in  1  FIFO dequeue valid
- req_addr_i  in  ADDR_WIDTH  line address of the request
- req_data_i  in  LINE_WIDTH  line data; beat 0 = bits [BEAT_WIDTH-1:0]
- req_rdy_o  out  1  FIFO dequeue ready
- flush_i  in  1  pipeline flush
- aw_vld_o  out  1  address phase valid
- aw_rdy_i  in  1  address phase ready
- aw_addr_o  out  ADDR_WIDTH  address, line-aligned
- aw_id_o  out  ID_WIDTH  transaction ID
- aw_len_o  out  8  beat count minus 1
- w_vld_o  out  1  data beat valid
- w_rdy_i  in  1  data beat ready
- w_data_o  out  BEAT_WIDTH  current beat
- w_last_o  out  1  final beat marker
- b_vld_i  in  1  response valid
- b_rdy_o  out  1  response ready
- b_resp_i  in  2  response code; 0 = OKAY, anything else = error
- busy_o  out  1  a request is held (state is not IDLE)
- err_o  out  1  one-cycle pulse when a request is dropped with an error

Behaviour:
- BEATS = LINE_WIDTH/BEAT_WIDTH. The beat counter is $clog2(BEATS) bits wide.
- States: IDLE, AW, W, B. All state, counters and output registers are clocked on clk.
- Reset: state = IDLE; aw_vld_o = w_vld_o = b_rdy_o = busy_o = err_o = 0; beat counter = 0; retry counter = 0; w_last_o = 0.
- req_rdy_o = (state == IDLE) & ~flush_i. It is combinational from state and flush_i.
- IDLE:
  - On req_vld_i & req_rdy_o: capture address (low log2(LINE_WIDTH/8) bits forced to 0) and data into internal registers, then go to AW next cycle.
  - No acceptance in a cycle where flush_i is high.
- AW:
  - aw_vld_o = 1; aw_len_o = BEATS-1; aw_addr_o and aw_id_o are stable while aw_vld_o is high.
  - On aw_rdy_i, go to W with beat counter = 0.
  - aw_vld_o never drops before the handshake.
- W:
  - w_vld_o = 1; w_data_o = captured beat[beat counter]; w_last_o = (beat counter == BEATS-1).
  - On w_rdy_i: beat counter increments. If w_last_o was set, go to B.
  - w_vld_o is held high, data stable, across stalls.
- B:
  - b_rdy_o = 1. On b_vld_i:
    - resp == 0: go to IDLE.
    - resp != 0: see Optional Feature.
  - err_o is registered and asserts in the cycle after the dropping response.
- Minimum turnaround per request, zero stalls: 1 (accept) + 1 (AW) + BEATS (W) + 1 (B) cycles. The next request can be accepted in the cycle after returning to IDLE.
- flush_i only blocks new acceptance. A transaction already accepted always completes on the bus; an aborted burst is illegal.
- rst during any state returns to IDLE the next cycle. Captured data is discarded and all bus valids drop immediately.
- b_vld_i outside state B is ignored (b_rdy_o = 0).
- Captured data registers need no reset.

Optional Feature:
- Macro: L1D_WB_ERR_RETRY_EN.
- Defined:
  - On error resp in B, if the 2-bit retry counter < 3: increment it, go back to AW, and replay the same address and data from beat 0. No err_o.
  - When the counter is already 3: drop the request, pulse err_o, go to IDLE.
  - The retry counter clears on each new acceptance.
- Undefined:
  - No retry counter logic.
  - An error resp drops the request, pulses err_o and goes to IDLE.

Test Plan:
- Reset, then one request with addr=0x12345_6789, data = beat k holds 64'hk, all readies = 1, resp=0 → aw_addr_o = 0x12345_6780, aw_len_o = 7, beats 0..7 in order, w_last_o only on beat 7, busy_o for 10 cycles, err_o = 0.
- w_rdy_i toggled 1,0,0,1,... → w_data_o and w_last_o stable during stalls; exactly 8 handshakes; req_rdy_o = 0 throughout.
- flush_i = 1 with req_vld_i = 1 in IDLE → req_rdy_o = 0 and no AW. flush_i raised mid-W → burst completes and returns to IDLE normally.
- Back-to-back requests with req_vld_i held high → second is accepted the cycle after the first's B handshake; no beat overlap.
- b_resp_i = 2'b10: without the macro → err_o pulses once and IDLE follows. With the macro and persistent error → 3 replays of the same 8 beats, then an err_o pulse.
- rst asserted in W at beat 3 → aw_vld_o = w_vld_o = 0 and state IDLE next cycle; the next request starts from beat 0.
